// File: rtl/sys_defs.sv
// Shared bus, access-size and controller-state definitions for the data-memory path.
package sys_defs;

  localparam logic [1:0] BUS_NONE  = 2'b00;
  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] BUS_STORE = 2'b10;

  localparam logic [2:0] SZ_BYTE   = 3'b000;
  localparam logic [2:0] SZ_HALF   = 3'b001;
  localparam logic [2:0] SZ_WORD   = 3'b010;
  localparam logic [2:0] SZ_BYTE_U = 3'b100;
  localparam logic [2:0] SZ_HALF_U = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a 32-bit word: store enables/data, load extraction and
// extension, plus the illegal-size / misalignment decode.
module dmem_lane_align
  import sys_defs::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_ext,
  output logic        bad_access
);

  logic [4:0]  shamt_s;
  logic [31:0] rshift_s;

  assign shamt_s  = {addr_lo, 3'b000};
  assign rshift_s = rword >> shamt_s;
  // Upper data bits land in lanes that byte_en leaves disabled.
  assign wdata_al = wdata << shamt_s;

  always_comb begin
    byte_en    = 4'b0000;
    rdata_ext  = 32'h0000_0000;
    bad_access = 1'b0;
    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        rdata_ext = {{24{rshift_s[7]}}, rshift_s[7:0]};
      end
      SZ_BYTE_U: begin
        byte_en   = 4'b0001 << addr_lo;
        rdata_ext = {24'h00_0000, rshift_s[7:0]};
      end
      SZ_HALF: begin
        byte_en    = 4'b0011 << addr_lo;
        rdata_ext  = {{16{rshift_s[15]}}, rshift_s[15:0]};
        bad_access = addr_lo[0];
      end
      SZ_HALF_U: begin
        byte_en    = 4'b0011 << addr_lo;
        rdata_ext  = {16'h0000, rshift_s[15:0]};
        bad_access = addr_lo[0];
      end
      SZ_WORD: begin
        byte_en    = 4'b1111;
        rdata_ext  = rword;
        bad_access = (addr_lo != 2'b00);
      end
      default: begin
        bad_access = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one MEM-stage request at a time, performs the
// SRAM access after LATENCY cycles and returns a one-cycle registered response.
module dmem_ctrl
  import sys_defs::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [31:0] proc2Dmem_addr,
  input  logic [31:0] proc2Dmem_data,
  input  logic [2:0]  proc2Dmem_size,
  output logic [31:0] Dmem2proc_data,
  output logic        Dmem2proc_valid,
  output logic        Dmem2proc_stall,
  output logic        Dmem2proc_misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY) + 1;
  localparam int LW = AW + 2;

  dmem_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [LW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    size_q, size_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          valid_q, valid_d;
  logic          mis_q, mis_d;

  logic [1:0]    acc_cmd_s;
  logic [LW-1:0] acc_addr_s;
  logic [31:0]   acc_wdata_s;
  logic [2:0]    acc_size_s;
  logic [3:0]    byte_en_s;
  logic [31:0]   wdata_al_s;
  logic [31:0]   rdata_ext_s;
  logic [31:0]   rword_s;
  logic          bad_s;
  logic          err_s;
  logic          access_s;
  logic          write_s;
  logic          unused_addr_s;

  logic [31:0]   mem_q [DEPTH_WORDS];

  // Address bits above the array wrap away.
  assign unused_addr_s = ^proc2Dmem_addr[31:LW];

  // In IDLE the live request is decoded; afterwards the latched copy drives the access.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_cmd_s   = proc2Dmem_command;
      acc_addr_s  = proc2Dmem_addr[LW-1:0];
      acc_wdata_s = proc2Dmem_data;
      acc_size_s  = proc2Dmem_size;
    end else begin
      acc_cmd_s   = cmd_q;
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;
      acc_size_s  = size_q;
    end
  end

  assign rword_s = mem_q[acc_addr_s[LW-1:2]];
  assign err_s   = bad_s || (acc_cmd_s == 2'b11);

  dmem_lane_align u_align (
    .addr_lo    (acc_addr_s[1:0]),
    .size       (acc_size_s),
    .wdata      (acc_wdata_s),
    .rword      (rword_s),
    .byte_en    (byte_en_s),
    .wdata_al   (wdata_al_s),
    .rdata_ext  (rdata_ext_s),
    .bad_access (bad_s)
  );

  // Next state, counter, request latches and the response registers' inputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    rdata_d  = 32'h0000_0000;
    valid_d  = 1'b0;
    mis_d    = 1'b0;
    access_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (proc2Dmem_command != BUS_NONE) begin
          cmd_d   = proc2Dmem_command;
          addr_d  = proc2Dmem_addr[LW-1:0];
          wdata_d = proc2Dmem_data;
          size_d  = proc2Dmem_size;
          if (err_s) begin
            state_d = ST_RESP;
            valid_d = 1'b1;
            mis_d   = 1'b1;
          end else if (LATENCY == 1) begin
            state_d  = ST_RESP;
            valid_d  = 1'b1;
            access_s = 1'b1;
            rdata_d  = (acc_cmd_s == BUS_LOAD) ? rdata_ext_s : 32'h0000_0000;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CW'(LATENCY - 2);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d  = ST_RESP;
          valid_d  = 1'b1;
          access_s = 1'b1;
          rdata_d  = (acc_cmd_s == BUS_LOAD) ? rdata_ext_s : 32'h0000_0000;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= BUS_NONE;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      size_q  <= 3'b000;
      rdata_q <= 32'h0000_0000;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign write_s = access_s && !rst && (acc_cmd_s == BUS_STORE);

  // Array storage is deliberately not reset; only enabled lanes are written.
  always_ff @(posedge clk) begin
    if (write_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s[i]) begin
          mem_q[acc_addr_s[LW-1:2]][8*i +: 8] <= wdata_al_s[8*i +: 8];
        end
      end
    end
  end

  assign Dmem2proc_data       = rdata_q;
  assign Dmem2proc_valid      = valid_q;
  assign Dmem2proc_misaligned = mis_q;
  assign Dmem2proc_stall      = !rst && (((state_q == ST_IDLE) && (proc2Dmem_command != BUS_NONE))
                                         || (state_q == ST_BUSY));

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed table, reset/latency corner cases and
// randomized traffic against a byte-array reference model.
module tb_dmem_ctrl;
  import sys_defs::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_v   [2];
  logic [1:0]  cmd_v   [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wd_v    [2];
  logic [2:0]  sz_v    [2];
  logic [31:0] rd_v    [2];
  logic        valid_v [2];
  logic        stall_v [2];
  logic        mis_v   [2];

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] ref_b [4*DEPTH];

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst_v[0]), .proc2Dmem_command(cmd_v[0]), .proc2Dmem_addr(addr_v[0]),
    .proc2Dmem_data(wd_v[0]), .proc2Dmem_size(sz_v[0]), .Dmem2proc_data(rd_v[0]),
    .Dmem2proc_valid(valid_v[0]), .Dmem2proc_stall(stall_v[0]), .Dmem2proc_misaligned(mis_v[0])
  );

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst_v[1]), .proc2Dmem_command(cmd_v[1]), .proc2Dmem_addr(addr_v[1]),
    .proc2Dmem_data(wd_v[1]), .proc2Dmem_size(sz_v[1]), .Dmem2proc_data(rd_v[1]),
    .Dmem2proc_valid(valid_v[1]), .Dmem2proc_stall(stall_v[1]), .Dmem2proc_misaligned(mis_v[1])
  );

  typedef struct {
    logic [1:0]  c;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  sz;
    logic [31:0] ed;
    logic        em;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, address wraps modulo 4*DEPTH bytes.
  task automatic ref_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] sz, output logic [31:0] ed, output logic em);
    int n;
    logic sgn;
    int base;
    n = 0; sgn = 1'b0;
    case (sz)
      3'b000: begin n = 1; sgn = 1'b1; end
      3'b001: begin n = 2; sgn = 1'b1; end
      3'b010: n = 4;
      3'b100: n = 1;
      3'b101: n = 2;
      default: n = 0;
    endcase
    em = (n == 0) || (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    ed = 32'h0;
    base = int'(a % (4 * DEPTH));
    if (!em) begin
      for (int i = 0; i < n; i++) begin
        if (c == BUS_STORE) ref_b[base + i] = wd[8*i +: 8];
        else ed[8*i +: 8] = ref_b[base + i];
      end
      if (c == BUS_LOAD && sgn && ed[8*n-1]) begin
        for (int i = n; i < 4; i++) ed[8*i +: 8] = 8'hFF;
      end
    end
  endtask

  // Issue one request and observe it mid-cycle until the response (bounded).
  task automatic run_req(input int d, input logic [1:0] c, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] sz,
                         output logic [31:0] rd, output logic rm, output int lat,
                         output int stalls, output logic quiet, output logic seen);
    @(negedge clk);
    cmd_v[d] = c; addr_v[d] = a; wd_v[d] = wd; sz_v[d] = sz;
    rd = 32'h0; rm = 1'b0; lat = 0; stalls = 0; quiet = 1'b1; seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (valid_v[d]) begin
        seen = 1'b1; lat = k; rd = rd_v[d]; rm = mis_v[d];
        if (stall_v[d]) quiet = 1'b0;
        break;
      end
      if (stall_v[d]) stalls++;
      if (rd_v[d] != 32'h0 || mis_v[d]) quiet = 1'b0;
      @(negedge clk);
    end
    cmd_v[d] = BUS_NONE;
  endtask

  task automatic check_req(input string name, input int d, input int latency,
                           input logic [1:0] c, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] sz, input logic [31:0] ed, input logic em);
    logic [31:0] rd; logic rm, quiet, seen; int lat, stalls, exp_lat;
    run_req(d, c, a, wd, sz, rd, rm, lat, stalls, quiet, seen);
    exp_lat = em ? 1 : latency;
    chk({name, "_seen"}, 32'(seen), 32'd1);
    chk({name, "_data"}, rd, ed);
    chk({name, "_mis"}, 32'(rm), 32'(em));
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_stall"}, stalls, exp_lat);
    chk({name, "_quiet"}, 32'(quiet), 32'd1);
  endtask

  initial begin
    logic [31:0] ed; logic em; logic seen_any;
    logic [1:0] c; logic [31:0] a; logic [2:0] sz;
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1; cmd_v[d] = BUS_LOAD; addr_v[d] = 32'h0; wd_v[d] = 32'h0; sz_v[d] = SZ_WORD;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall_v[0]), 32'd0);
    chk("rst_valid", 32'(valid_v[0]), 32'd0);
    chk("rst_data", rd_v[0], 32'h0);
    chk("rst_mis", 32'(mis_v[0]), 32'd0);
    cmd_v[0] = BUS_NONE; cmd_v[1] = BUS_NONE;
    @(negedge clk);
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;

    tbl[0]  = '{BUS_STORE, 32'h100,  32'hDEADBEEF, SZ_WORD,   32'h0,        1'b0};
    tbl[1]  = '{BUS_LOAD,  32'h100,  32'h0,        SZ_WORD,   32'hDEADBEEF, 1'b0};
    tbl[2]  = '{BUS_STORE, 32'h103,  32'h80,       SZ_BYTE,   32'h0,        1'b0};
    tbl[3]  = '{BUS_LOAD,  32'h103,  32'h0,        SZ_BYTE,   32'hFFFFFF80, 1'b0};
    tbl[4]  = '{BUS_LOAD,  32'h103,  32'h0,        SZ_BYTE_U, 32'h00000080, 1'b0};
    tbl[5]  = '{BUS_LOAD,  32'h100,  32'h0,        SZ_WORD,   32'h80ADBEEF, 1'b0};
    tbl[6]  = '{BUS_STORE, 32'h102,  32'h8001,     SZ_HALF,   32'h0,        1'b0};
    tbl[7]  = '{BUS_LOAD,  32'h102,  32'h0,        SZ_HALF,   32'hFFFF8001, 1'b0};
    tbl[8]  = '{BUS_LOAD,  32'h102,  32'h0,        SZ_HALF_U, 32'h00008001, 1'b0};
    tbl[9]  = '{BUS_LOAD,  32'h101,  32'h0,        SZ_BYTE,   32'hFFFFFFBE, 1'b0};
    tbl[10] = '{BUS_LOAD,  32'h100,  32'h0,        SZ_HALF,   32'hFFFFBEEF, 1'b0};
    tbl[11] = '{BUS_STORE, 32'h200,  32'h11223344, SZ_WORD,   32'h0,        1'b0};
    tbl[12] = '{BUS_LOAD,  32'h101,  32'h0,        SZ_WORD,   32'h0,        1'b1};
    tbl[13] = '{BUS_STORE, 32'h203,  32'hFFFF,     SZ_HALF,   32'h0,        1'b1};
    tbl[14] = '{BUS_LOAD,  32'h200,  32'h0,        SZ_WORD,   32'h11223344, 1'b0};
    tbl[15] = '{BUS_STORE, 32'h1008, 32'h12345678, SZ_WORD,   32'h0,        1'b0};
    tbl[16] = '{BUS_LOAD,  32'h8,    32'h0,        SZ_WORD,   32'h12345678, 1'b0};
    tbl[17] = '{BUS_LOAD,  32'h8,    32'h0,        3'b011,    32'h0,        1'b1};
    tbl[18] = '{BUS_LOAD,  32'h202,  32'h0,        SZ_BYTE_U, 32'h00000022, 1'b0};

    for (int i = 0; i < 19; i++) begin
      ref_op(tbl[i].c, tbl[i].a, tbl[i].wd, tbl[i].sz, ed, em);
      check_req($sformatf("tbl%0d", i), 0, 2, tbl[i].c, tbl[i].a, tbl[i].wd, tbl[i].sz,
                tbl[i].ed, tbl[i].em);
    end

    // LATENCY=4: reset during BUSY abandons the store.
    check_req("l4_sw", 1, 4, BUS_STORE, 32'h40, 32'hAAAA5555, SZ_WORD, 32'h0, 1'b0);
    @(negedge clk);
    cmd_v[1] = BUS_STORE; addr_v[1] = 32'h40; wd_v[1] = 32'h5; sz_v[1] = SZ_WORD;
    @(negedge clk);
    #1;
    chk("l4_busy_stall", 32'(stall_v[1]), 32'd1);
    addr_v[1] = 32'h44;
    @(negedge clk);
    rst_v[1] = 1'b1;
    #1;
    chk("l4_rst_stall", 32'(stall_v[1]), 32'd0);
    chk("l4_rst_valid", 32'(valid_v[1]), 32'd0);
    chk("l4_rst_data", rd_v[1], 32'h0);
    cmd_v[1] = BUS_NONE;
    @(negedge clk);
    rst_v[1] = 1'b0;
    seen_any = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (valid_v[1]) seen_any = 1'b1;
    end
    chk("l4_no_valid", 32'(seen_any), 32'd0);
    check_req("l4_lw", 1, 4, BUS_LOAD, 32'h40, 32'h0, SZ_WORD, 32'hAAAA5555, 1'b0);
    check_req("l4_err", 1, 4, BUS_LOAD, 32'h41, 32'h0, SZ_WORD, 32'h0, 1'b1);

    // Randomized traffic on a preloaded region, with aliased upper address bits.
    for (int w = 0; w < 16; w++) begin
      a = 32'h300 + 32'(4 * w);
      ref_op(BUS_STORE, a, $urandom, SZ_WORD, ed, em);
      check_req("init", 0, 2, BUS_STORE, a, {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]},
                SZ_WORD, 32'h0, 1'b0);
    end
    for (int i = 0; i < 150; i++) begin
      logic [31:0] wd;
      c  = ($urandom_range(0, 1) == 0) ? BUS_LOAD : BUS_STORE;
      a  = 32'h300 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 7)) << 12);
      sz = 3'($urandom_range(0, 9));
      if (sz > 3'd7 || $urandom_range(0, 9) > 7) sz = SZ_WORD;
      wd = $urandom;
      ref_op(c, a, wd, sz, ed, em);
      check_req($sformatf("rnd%0d", i), 0, 2, c, a, wd, sz, ed, em);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
